// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet MAC datapath.
//   - tx_state_e  : transmit FSM states
//   - byte/CRC constants used on the wire
//   - crc32_d8()  : one-byte step of the reflected CRC-32 (poly 0xEDB88320)
package eth_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    // LSB-first shift: the byte enters bit 0 first, matching Ethernet bit order.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: registered byte-wide CRC-32 accumulator.
// Ports:
//   clk_i  - clock (posedge)
//   rst_ni - asynchronous active-low reset; register returns to CRC_INIT
//   init_i - load CRC_INIT on the next edge (priority over en_i)
//   en_i   - fold data_i into the CRC on the next edge
//   data_i - byte to fold
//   crc_o  - current (non-inverted) CRC register
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_d8(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_mac_tx.sv
// eth_mac_tx: Ethernet MAC transmitter feeding an 8-bit SDR MAC_TXV/MAC_TXD path.
// Emits preamble, SFD, the upstream frame bytes, optional zero pad and the CRC-32 FCS,
// then holds the inter-frame gap.
// Build option: define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
// Ports:
//   MAC_TXC    - transmit clock, posedge
//   MAC_RST_N  - asynchronous active-low reset
//   S_DATA     - upstream frame byte
//   S_VALID    - upstream byte valid; starts a frame when seen in idle
//   S_LAST     - final frame byte marker
//   S_READY    - combinational; high only while streaming the payload
//   MAC_TXV    - registered data valid
//   MAC_TXD    - registered data byte
//   FRAME_DONE - one-cycle pulse in the first idle cycle after the FCS
//   UNDERRUN   - one-cycle pulse when a frame is aborted for lack of data
module eth_mac_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic       MAC_TXC,
    input  logic       MAC_RST_N,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    input  logic       S_LAST,
    output logic       S_READY,
    output logic       MAC_TXV,
    output logic [7:0] MAC_TXD,
    output logic       FRAME_DONE,
    output logic       UNDERRUN
);

    localparam logic [15:0] PreLast  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IfgLast  = 16'(IFG_LEN - 1);
    localparam logic [11:0] MinFrame = 12'(MIN_FRAME);
    localparam logic [10:0] CntMax   = 11'h7FF;

    tx_state_e   state_q;
    logic [15:0] phase_q;
    logic [10:0] cnt_q;
    logic        txv_q;
    logic [7:0]  txd_q;
    logic        frame_done_q;
    logic        underrun_q;
    logic        done_pend_q;

    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [10:0] cnt_inc;
    logic [11:0] cnt_next;
    logic        hs;

    assign S_READY  = (state_q == StPayload);
    assign hs       = S_READY & S_VALID;
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;
    // Unsaturated count including the byte leaving this cycle; 12 bits so it cannot wrap.
    assign cnt_next = {1'b0, cnt_q} + 12'd1;

    assign crc_init = (state_q == StSfd);
    assign crc_en   = hs || (state_q == StPad);
    assign crc_data = (state_q == StPad) ? 8'h00 : S_DATA;
    assign fcs      = ~crc;

    eth_crc32_d8 u_crc (
        .clk_i  (MAC_TXC),
        .rst_ni (MAC_RST_N),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (crc_data),
        .crc_o  (crc)
    );

    always_ff @(posedge MAC_TXC or negedge MAC_RST_N) begin
        if (!MAC_RST_N) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            cnt_q        <= '0;
            txv_q        <= 1'b0;
            txd_q        <= 8'h00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            done_pend_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    txv_q <= 1'b0;
                    txd_q <= 8'h00;
                    if (S_VALID) begin
                        state_q <= StPre;
                        phase_q <= '0;
                    end
                end
                StPre: begin
                    txv_q   <= 1'b1;
                    txd_q   <= PREAMBLE_BYTE;
                    phase_q <= phase_q + 16'd1;
                    if (phase_q == PreLast) begin
                        state_q <= StSfd;
                    end
                end
                StSfd: begin
                    txv_q   <= 1'b1;
                    txd_q   <= SFD_BYTE;
                    cnt_q   <= '0;
                    state_q <= StPayload;
                end
                StPayload: begin
                    if (S_VALID) begin
                        txv_q <= 1'b1;
                        txd_q <= S_DATA;
                        cnt_q <= cnt_inc;
                        if (S_LAST) begin
`ifdef ETH_TX_PAD_EN
                            if (cnt_next < MinFrame) begin
                                state_q <= StPad;
                            end else
`endif
                            begin
                                state_q <= StFcs;
                                phase_q <= '0;
                            end
                        end
                    end else begin
                        // Upstream ran dry mid-frame: drop the frame without an FCS.
                        txv_q       <= 1'b0;
                        txd_q       <= 8'h00;
                        underrun_q  <= 1'b1;
                        done_pend_q <= 1'b0;
                        state_q     <= StIfg;
                        phase_q     <= '0;
                    end
                end
                StPad: begin
                    txv_q <= 1'b1;
                    txd_q <= 8'h00;
                    cnt_q <= cnt_inc;
                    if (cnt_next >= MinFrame) begin
                        state_q <= StFcs;
                        phase_q <= '0;
                    end
                end
                StFcs: begin
                    txv_q   <= 1'b1;
                    txd_q   <= fcs[{phase_q[1:0], 3'b000} +: 8];
                    phase_q <= phase_q + 16'd1;
                    if (phase_q[1:0] == 2'd3) begin
                        state_q     <= StIfg;
                        phase_q     <= '0;
                        done_pend_q <= 1'b1;
                    end
                end
                StIfg: begin
                    txv_q <= 1'b0;
                    txd_q <= 8'h00;
                    // Pulse lands on the first idle cycle after a completed FCS only.
                    frame_done_q <= done_pend_q;
                    done_pend_q  <= 1'b0;
                    phase_q      <= phase_q + 16'd1;
                    if (phase_q == IfgLast) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign MAC_TXV    = txv_q;
    assign MAC_TXD    = txd_q;
    assign FRAME_DONE = frame_done_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_eth_mac_tx.sv
module tb_eth_mac_tx;

    localparam int unsigned PreLen   = 7;
    localparam int unsigned MinFrame = 60;
    localparam int unsigned IfgLen   = 12;
`ifdef ETH_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic       MAC_TXC   = 1'b0;
    logic       MAC_RST_N = 1'b0;
    logic [7:0] S_DATA    = 8'h00;
    logic       S_VALID   = 1'b0;
    logic       S_LAST    = 1'b0;
    logic       S_READY;
    logic       MAC_TXV;
    logic [7:0] MAC_TXD;
    logic       FRAME_DONE;
    logic       UNDERRUN;

    eth_mac_tx #(
        .PREAMBLE_LEN (PreLen),
        .MIN_FRAME    (MinFrame),
        .IFG_LEN      (IfgLen)
    ) dut (
        .MAC_TXC    (MAC_TXC),
        .MAC_RST_N  (MAC_RST_N),
        .S_DATA     (S_DATA),
        .S_VALID    (S_VALID),
        .S_LAST     (S_LAST),
        .S_READY    (S_READY),
        .MAC_TXV    (MAC_TXV),
        .MAC_TXD    (MAC_TXD),
        .FRAME_DONE (FRAME_DONE),
        .UNDERRUN   (UNDERRUN)
    );

    always #4 MAC_TXC = ~MAC_TXC;

    typedef struct {
        int len;      // expected MAC_TXV=1 run length
        bit aborted;  // underrun expected instead of FRAME_DONE
        bit b2b;      // S_VALID held into this frame from the previous one
    } frame_t;

    frame_t      fq[$];
    logic [7:0]  exp_q[$];
    logic [31:0] crc_tab [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Table-driven reference CRC over a whole frame.
    function automatic void build_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic logic [31:0] model_fcs(input logic [7:0] fr[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fr[i]) c = crc_tab[c[7:0] ^ fr[i]] ^ (c >> 8);
        return ~c;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit     prev_txv     = 1'b0;
    bit     have_prev    = 1'b0;
    bit     last_aborted = 1'b0;
    int     run_len      = 0;
    int     gap          = 0;
    int     gap_want     = 0;
    frame_t mon_f;

    always @(negedge MAC_TXC) begin
        if (mon_en) begin
            if (MAC_TXV) begin
                if (!prev_txv) begin
                    if (fq.size() == 0) begin
                        check("frame_expected", 32'd0, 32'd1);
                    end else if (have_prev) begin
                        gap_want = last_aborted ? int'(IfgLen) + 2 : int'(IfgLen) + 1;
                        if (fq[0].b2b) check("gap_exact", 32'(gap), 32'(gap_want));
                        else check("gap_min", (gap >= gap_want) ? 32'(gap_want) : 32'(gap),
                                   32'(gap_want));
                    end
                    run_len = 0;
                end
                run_len++;
                if (exp_q.size() == 0) check("byte_expected", 32'd0, 32'd1);
                else check("txd", 32'(MAC_TXD), 32'(exp_q.pop_front()));
                check("done_in_frame", 32'(FRAME_DONE), 32'd0);
                check("underrun_in_frame", 32'(UNDERRUN), 32'd0);
            end else begin
                if (prev_txv) begin
                    if (fq.size() == 0) begin
                        check("frame_record", 32'd0, 32'd1);
                    end else begin
                        mon_f = fq.pop_front();
                        check("valid_len", 32'(run_len), 32'(mon_f.len));
                        check("frame_done", 32'(FRAME_DONE), 32'(!mon_f.aborted));
                        check("underrun", 32'(UNDERRUN), 32'(mon_f.aborted));
                        last_aborted = mon_f.aborted;
                    end
                    check("idle_txd", 32'(MAC_TXD), 32'd0);
                    have_prev = 1'b1;
                    gap       = 0;
                end else begin
                    check("spurious_done", 32'(FRAME_DONE), 32'd0);
                    check("spurious_underrun", 32'(UNDERRUN), 32'd0);
                end
                gap++;
            end
            prev_txv = MAC_TXV;
        end
    end

    // ---------------- driver ----------------
    task automatic idle_cycles(input int n);
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        repeat (n) begin
            @(posedge MAC_TXC);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int   n;
        logic rdy;
        S_DATA  = b;
        S_LAST  = last;
        S_VALID = 1'b1;
        n       = 0;
        forever begin
            @(negedge MAC_TXC);
            rdy = S_READY;
            @(posedge MAC_TXC);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic run_frame(input int len, input int abort_n, input bit b2b, input bit kat);
        logic [7:0]  pay[$];
        logic [7:0]  fr[$];
        logic [31:0] fcs;
        frame_t      rec;
        for (int i = 0; i < len; i++) pay.push_back(kat ? 8'(8'h31 + i) : 8'($urandom));
        for (int i = 0; i < int'(PreLen); i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        rec.b2b     = b2b;
        rec.aborted = (abort_n != 0);
        if (abort_n != 0) begin
            for (int i = 0; i < abort_n; i++) exp_q.push_back(pay[i]);
            rec.len = int'(PreLen) + 1 + abort_n;
        end else begin
            fr = pay;
            if (PadEn) while (fr.size() < MinFrame) fr.push_back(8'h00);
            fcs = model_fcs(fr);
            if (kat && !PadEn) fcs = 32'hCBF43926;  // published check value of "123456789"
            foreach (fr[i]) exp_q.push_back(fr[i]);
            for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
            rec.len = int'(PreLen) + 1 + fr.size() + 4;
        end
        fq.push_back(rec);
        if (!b2b) idle_cycles($urandom_range(1, 30));
        if (abort_n != 0) begin
            for (int i = 0; i < abort_n; i++) send_byte(pay[i], 1'b0);
            S_VALID = 1'b0;
            S_LAST  = 1'b0;
            @(posedge MAC_TXC);
            #1;
        end else begin
            for (int i = 0; i < len; i++) send_byte(pay[i], i == len - 1);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int len;
        int ab;
        build_tab();

        #20;
        check("rst_txv", 32'(MAC_TXV), 32'd0);
        check("rst_txd", 32'(MAC_TXD), 32'd0);
        check("rst_ready", 32'(S_READY), 32'd0);
        check("rst_done", 32'(FRAME_DONE), 32'd0);
        check("rst_underrun", 32'(UNDERRUN), 32'd0);
        #3 MAC_RST_N = 1'b1;
        idle_cycles(5);
        check("idle_txv", 32'(MAC_TXV), 32'd0);
        check("idle_txd", 32'(MAC_TXD), 32'd0);
        check("idle_ready", 32'(S_READY), 32'd0);

        mon_en = 1'b1;
        run_frame(9, 0, 1'b0, 1'b1);
        run_frame(64, 0, 1'b0, 1'b0);
        run_frame(59, 0, 1'b1, 1'b0);
        run_frame(60, 0, 1'b0, 1'b0);
        run_frame(30, 20, 1'b1, 1'b0);
        run_frame(1, 0, 1'b1, 1'b0);
        run_frame(61, 0, 1'b1, 1'b0);
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 100);
            ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
            run_frame(len, ab, 1'($urandom_range(0, 1)), 1'b0);
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        for (int t = 0; t < 5000 && fq.size() != 0; t++) @(posedge MAC_TXC);
        #1;
        check("drain_frames", 32'(fq.size()), 32'd0);
        check("drain_bytes", 32'(exp_q.size()), 32'd0);
        idle_cycles(20);
        mon_en = 1'b0;

        // Reset asserted while the preamble is on the wire.
        S_VALID = 1'b1;
        repeat (3) @(posedge MAC_TXC);
        #1;
        check("pre_txv", 32'(MAC_TXV), 32'd1);
        check("pre_txd", 32'(MAC_TXD), 32'h55);
        #2 MAC_RST_N = 1'b0;
        #1;
        check("async_rst_txv", 32'(MAC_TXV), 32'd0);
        check("async_rst_txd", 32'(MAC_TXD), 32'd0);
        check("async_rst_ready", 32'(S_READY), 32'd0);
        S_VALID = 1'b0;
        #10 MAC_RST_N = 1'b1;
        idle_cycles(3);
        check("post_rst_txv", 32'(MAC_TXV), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
